// File: rtl/frog_timer_sequencer.sv
// Round countdown sequencer: divides frame_tick into seconds and runs a two-digit BCD countdown.
// Optional bonus crediting is compiled in with `define FROG_TIMER_BONUS_EN.
module frog_timer_sequencer #(
   parameter int FRAMES_PER_SEC = 60,
   parameter int START_SECONDS  = 60,
   parameter int BONUS_SECONDS  = 10
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       pause,
   input  logic       stop,
   input  logic       bonus,
   output logic [3:0] tens_digit,
   output logic [3:0] ones_digit,
   output logic       running,
   output logic       sec_tick,
   output logic       timeout
);

   localparam int CW = $clog2(FRAMES_PER_SEC);
   localparam logic [CW-1:0] FRAME_LAST = CW'(FRAMES_PER_SEC - 1);
   localparam logic [3:0] START_TENS = 4'(START_SECONDS / 10);
   localparam logic [3:0] START_ONES = 4'(START_SECONDS % 10);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

   state_t        state, state_d;
   logic [CW-1:0] frame_cnt, frame_cnt_d;
   logic [3:0]    tens_d, ones_d;
   logic          sec_tick_d, timeout_d;
   logic          at_zero;

`ifdef FROG_TIMER_BONUS_EN
   localparam logic [3:0] BONUS_TENS   = 4'(BONUS_SECONDS / 10);
   localparam logic [3:0] BONUS_ONES   = 4'(BONUS_SECONDS % 10);
   localparam logic [3:0] BONUS_M1_TENS = 4'((BONUS_SECONDS - 1) / 10);
   localparam logic [3:0] BONUS_M1_ONES = 4'((BONUS_SECONDS - 1) % 10);
   logic [4:0] sum_ones, sum_tens;
`else
   logic unused_bonus;
   assign unused_bonus = bonus;
`endif

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state;
      tens_d      = tens_digit;
      ones_d      = ones_digit;
      frame_cnt_d = frame_cnt;
      sec_tick_d  = 1'b0;
      timeout_d   = 1'b0;
      at_zero     = 1'b0;
`ifdef FROG_TIMER_BONUS_EN
      sum_ones    = '0;
      sum_tens    = '0;
`endif

      if (start) begin
         tens_d      = START_TENS;
         ones_d      = START_ONES;
         frame_cnt_d = '0;
         state_d     = pause ? S_PAUSED : S_RUN;
      end else if (stop && (state == S_RUN || state == S_PAUSED)) begin
         state_d = S_IDLE;
      end else begin
         case (state)
            S_RUN: begin
               if (pause) begin
                  state_d = S_PAUSED;
               end else if (frame_tick) begin
                  if (frame_cnt == FRAME_LAST) begin
                     frame_cnt_d = '0;
                     sec_tick_d  = 1'b1;
                     if (ones_digit == 4'd0 && tens_digit != 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_digit - 4'd1;
                     end else if (ones_digit != 4'd0) begin
                        ones_d = ones_digit - 4'd1;
                     end
                     at_zero = (tens_d == 4'd0) && (ones_d == 4'd0);
                  end else begin
                     frame_cnt_d = frame_cnt + CW'(1);
                  end
               end
            end
            S_PAUSED: if (!pause) state_d = S_RUN;
            default: ;
         endcase

`ifdef FROG_TIMER_BONUS_EN
         // A credit landing on the final decrement rescues the round with BONUS_SECONDS-1 left.
         if (bonus && (state == S_RUN || state == S_PAUSED)) begin
            if (at_zero) begin
               tens_d  = BONUS_M1_TENS;
               ones_d  = BONUS_M1_ONES;
               at_zero = (BONUS_SECONDS == 1);
            end else begin
               sum_ones = {1'b0, ones_d} + {1'b0, BONUS_ONES};
               sum_tens = {1'b0, tens_d} + {1'b0, BONUS_TENS};
               if (sum_ones > 5'd9) begin
                  sum_ones = sum_ones - 5'd10;
                  sum_tens = sum_tens + 5'd1;
               end
               if (sum_tens > 5'd9) begin
                  tens_d = 4'd9;
                  ones_d = 4'd9;
               end else begin
                  tens_d = sum_tens[3:0];
                  ones_d = sum_ones[3:0];
               end
            end
         end
`endif

         if (at_zero) begin
            state_d   = S_EXPIRED;
            timeout_d = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= S_IDLE;
         tens_digit <= 4'd0;
         ones_digit <= 4'd0;
         frame_cnt  <= '0;
         running    <= 1'b0;
         sec_tick   <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_d;
         tens_digit <= tens_d;
         ones_digit <= ones_d;
         frame_cnt  <= frame_cnt_d;
         running    <= (state_d == S_RUN);
         sec_tick   <= sec_tick_d;
         timeout    <= timeout_d;
      end
   end

endmodule

// File: tb/tb_frog_timer_sequencer.sv
// Randomized self-checking bench for frog_timer_sequencer against an integer-seconds reference model.
module tb_frog_timer_sequencer;

   localparam int FPS   = 60;
   localparam int START = 60;
   localparam int BONUS = 10;

   logic       Clk = 1'b0, Reset_n = 1'b0;
   logic       frame_tick = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0, bonus = 1'b0;
   logic [3:0] tens_digit, ones_digit;
   logic       running, sec_tick, timeout;

   int n_cmp = 0, n_bad = 0;
   int dut_sec = 0, dut_to = 0, to_not_zero = 0;

   typedef enum {M_IDLE, M_RUN, M_PAUSED, M_EXPIRED} m_state_t;
   m_state_t m_state = M_IDLE;
   int m_secs = 0, m_fc = 0, m_sec = 0, m_to = 0, m_bonus_seen = 0;
   bit m_sec_p = 0, m_to_p = 0;

   frog_timer_sequencer #(.FRAMES_PER_SEC(FPS), .START_SECONDS(START), .BONUS_SECONDS(BONUS)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start), .pause(pause),
      .stop(stop), .bonus(bonus), .tens_digit(tens_digit), .ones_digit(ones_digit),
      .running(running), .sec_tick(sec_tick), .timeout(timeout));

   always #5 Clk = ~Clk;

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      m_state = M_IDLE; m_secs = 0; m_fc = 0; m_sec_p = 0; m_to_p = 0;
   endtask

   // Reference: remaining time kept as plain integer seconds.
   task automatic model_step(input bit st, sp, ps, ft, bn);
      m_state_t old = m_state;
      bit landed = 0;
      m_sec_p = 0; m_to_p = 0;
      m_bonus_seen += int'(bn);
      if (st) begin
         m_secs = START; m_fc = 0; m_state = ps ? M_PAUSED : M_RUN;
      end else if (sp && (old == M_RUN || old == M_PAUSED)) begin
         m_state = M_IDLE;
      end else begin
         if (old == M_RUN && ps) m_state = M_PAUSED;
         else if (old == M_RUN && ft) begin
            m_fc++;
            if (m_fc == FPS) begin
               m_fc = 0; m_sec_p = 1;
               if (m_secs > 0) m_secs--;
               landed = (m_secs == 0);
            end
         end else if (old == M_PAUSED && !ps) m_state = M_RUN;
`ifdef FROG_TIMER_BONUS_EN
         if (bn && (old == M_RUN || old == M_PAUSED)) begin
            if (landed) begin
               m_secs = BONUS - 1; landed = (m_secs == 0);
            end else m_secs = (m_secs + BONUS > 99) ? 99 : m_secs + BONUS;
         end
`endif
         if (landed) begin m_state = M_EXPIRED; m_to_p = 1; end
      end
      m_sec += int'(m_sec_p);
      m_to  += int'(m_to_p);
   endtask

   task automatic drive(input bit st, sp, ps, ft, bn);
      @(negedge Clk);
      start = st; stop = sp; pause = ps; frame_tick = ft; bonus = bn;
      model_step(st, sp, ps, ft, bn);
      @(posedge Clk); #1;
      if (sec_tick) dut_sec++;
      if (timeout) begin
         dut_to++;
         if (tens_digit != 4'd0 || ones_digit != 4'd0) to_not_zero++;
      end
   endtask

   // n frame ticks with random idle gaps between them
   task automatic ticks(input int n, input bit ps = 1'b0);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(3) == 0) drive(0, 0, ps, 0, 0);
         drive(0, 0, ps, 1, 0);
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      #12;
      n_cmp++; if ({tens_digit, ones_digit, running, sec_tick, timeout} !== 11'b0) begin n_bad++;
         $display("FAIL reset_values: got %b want all zero", {tens_digit, ones_digit, running, sec_tick, timeout}); end
      @(negedge Clk); Reset_n = 1'b1;
      model_reset();
      ticks(70);
      n_cmp++; if ({tens_digit, ones_digit, running} !== 9'b0 || dut_sec !== 0) begin n_bad++;
         $display("FAIL idle_ignores_ticks: got %h/%0d run=%b secs=%0d want 00 run=0 secs=0", tens_digit, ones_digit, running, dut_sec); end
   endtask

   task automatic test_countdown();
      int s0 = dut_sec, t0 = dut_to;
      drive(1, 0, 0, 0, 0);
      n_cmp++; if ({tens_digit, ones_digit, running} !== {8'h60, 1'b1}) begin n_bad++;
         $display("FAIL start_load: got %h%h run=%b want 60 run=1", tens_digit, ones_digit, running); end
      ticks(FPS);
      n_cmp++; if ({tens_digit, ones_digit, running} !== {8'h59, 1'b1} || dut_sec - s0 !== 1) begin n_bad++;
         $display("FAIL first_second: got %h%h run=%b sec=%0d want 59 run=1 sec=1", tens_digit, ones_digit, running, dut_sec - s0); end
      ticks(59 * FPS);
      n_cmp++; if ({tens_digit, ones_digit, running} !== 9'b0) begin n_bad++;
         $display("FAIL expiry_state: got %h%h run=%b want 00 run=0", tens_digit, ones_digit, running); end
      n_cmp++; if (dut_to - t0 !== 1 || dut_sec - s0 !== 60 || to_not_zero !== 0) begin n_bad++;
         $display("FAIL expiry_pulses: got to=%0d sec=%0d offzero=%0d want 1 60 0", dut_to - t0, dut_sec - s0, to_not_zero); end
      ticks(100);
      n_cmp++; if ({tens_digit, ones_digit} !== 8'h00 || dut_to - t0 !== 1 || dut_sec - s0 !== 60) begin n_bad++;
         $display("FAIL expired_hold: got %h%h to=%0d sec=%0d want 00 1 60", tens_digit, ones_digit, dut_to - t0, dut_sec - s0); end
   endtask

   task automatic test_pause();
      int s0;
      drive(1, 0, 0, 0, 0);
      ticks(15 * FPS + 30);
      n_cmp++; if ({tens_digit, ones_digit} !== 8'h45 || m_fc !== 30) begin n_bad++;
         $display("FAIL pause_setup: got %h%h want 45", tens_digit, ones_digit); end
      s0 = dut_sec;
      repeat (200) drive(0, 0, 1, 1, 0);
      n_cmp++; if ({tens_digit, ones_digit, running} !== {8'h45, 1'b0} || dut_sec !== s0) begin n_bad++;
         $display("FAIL pause_freeze: got %h%h run=%b sec=%0d want 45 run=0 sec=0", tens_digit, ones_digit, running, dut_sec - s0); end
      drive(0, 0, 0, 0, 0);
      n_cmp++; if (running !== 1'b1) begin n_bad++;
         $display("FAIL pause_resume: got run=%b want 1", running); end
      ticks(FPS - 31);
      n_cmp++; if ({tens_digit, ones_digit} !== 8'h45 || dut_sec !== s0) begin n_bad++;
         $display("FAIL pause_cnt_held: got %h%h sec=%0d want 45 sec=0", tens_digit, ones_digit, dut_sec - s0); end
      ticks(1);
      n_cmp++; if ({tens_digit, ones_digit} !== 8'h44 || dut_sec - s0 !== 1) begin n_bad++;
         $display("FAIL pause_next_sec: got %h%h sec=%0d want 44 sec=1", tens_digit, ones_digit, dut_sec - s0); end
   endtask

   task automatic test_stop();
      int s0;
      drive(1, 0, 0, 0, 0);
      ticks(33 * FPS + FPS - 1);
      s0 = dut_sec;
      drive(0, 1, 0, 1, 0);
      n_cmp++; if ({tens_digit, ones_digit, running, sec_tick} !== {8'h27, 2'b00}) begin n_bad++;
         $display("FAIL stop_discards_tick: got %h%h run=%b sec=%b want 27 run=0 sec=0", tens_digit, ones_digit, running, sec_tick); end
      ticks(500);
      drive(0, 1, 0, 0, 0);
      n_cmp++; if ({tens_digit, ones_digit, running} !== {8'h27, 1'b0} || dut_sec !== s0) begin n_bad++;
         $display("FAIL stop_hold: got %h%h run=%b sec=%0d want 27 run=0 sec=0", tens_digit, ones_digit, running, dut_sec - s0); end
      drive(1, 1, 0, 0, 0);
      n_cmp++; if ({tens_digit, ones_digit, running} !== {8'h60, 1'b1}) begin n_bad++;
         $display("FAIL start_beats_stop: got %h%h run=%b want 60 run=1", tens_digit, ones_digit, running); end
   endtask

`ifdef FROG_TIMER_BONUS_EN
   task automatic test_bonus();
      int t0;
      drive(1, 0, 0, 0, 0);
      ticks(5 * FPS);
      repeat (4) drive(0, 0, 0, 0, 1);
      n_cmp++; if ({tens_digit, ones_digit} !== 8'h95) begin n_bad++;
         $display("FAIL bonus_add: got %h%h want 95", tens_digit, ones_digit); end
      drive(0, 0, 1, 0, 1);
      n_cmp++; if ({tens_digit, ones_digit} !== 8'h99) begin n_bad++;
         $display("FAIL bonus_saturate: got %h%h want 99", tens_digit, ones_digit); end
      drive(0, 0, 0, 0, 0);
      ticks(98 * FPS + FPS - 1);
      t0 = dut_to;
      drive(0, 0, 0, 1, 1);
      n_cmp++; if ({tens_digit, ones_digit, running} !== {8'h09, 1'b1} || dut_to !== t0) begin n_bad++;
         $display("FAIL bonus_rescue: got %h%h run=%b to=%0d want 09 run=1 to=0", tens_digit, ones_digit, running, dut_to - t0); end
      ticks(9 * FPS);
      drive(0, 0, 0, 0, 1);
      n_cmp++; if ({tens_digit, ones_digit, running} !== 9'b0 || dut_to - t0 !== 1) begin n_bad++;
         $display("FAIL bonus_expired: got %h%h run=%b to=%0d want 00 run=0 to=1", tens_digit, ones_digit, running, dut_to - t0); end
   endtask
`else
   task automatic test_bonus();
      drive(1, 0, 0, 0, 0);
      ticks(FPS);
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 1, 0, 1);
      n_cmp++; if ({tens_digit, ones_digit} !== 8'h59) begin n_bad++;
         $display("FAIL bonus_ignored: got %h%h want 59", tens_digit, ones_digit); end
   endtask
`endif

   task automatic test_reset_midrun();
      int s0;
      drive(1, 0, 0, 0, 0);
      ticks(27 * FPS);
      n_cmp++; if ({tens_digit, ones_digit} !== 8'h33) begin n_bad++;
         $display("FAIL midrun_setup: got %h%h want 33", tens_digit, ones_digit); end
      @(negedge Clk); #2 Reset_n = 1'b0;
      #1;
      n_cmp++; if ({tens_digit, ones_digit, running} !== 9'b0) begin n_bad++;
         $display("FAIL async_reset: got %h%h run=%b want 00 run=0", tens_digit, ones_digit, running); end
      @(negedge Clk); Reset_n = 1'b1;
      model_reset();
      s0 = dut_sec;
      ticks(100);
      n_cmp++; if ({tens_digit, ones_digit, running} !== 9'b0 || dut_sec !== s0) begin n_bad++;
         $display("FAIL reset_no_resume: got %h%h run=%b sec=%0d want 00 run=0 sec=0", tens_digit, ones_digit, running, dut_sec - s0); end
   endtask

   task automatic test_random();
      bit p = 0, st, sp, ft, bn;
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(99) == 0) p = ~p;
         st = ($urandom_range(1999) == 0);
         sp = ($urandom_range(999) == 0);
         ft = ($urandom_range(5) != 0);
         bn = ($urandom_range(149) == 0);
         drive(st, sp, p, ft, bn);
         n_cmp++;
         if ({tens_digit, ones_digit, running, sec_tick, timeout} !==
             {bcd(m_secs), m_state == M_RUN, m_sec_p, m_to_p}) begin
            n_bad++;
            $display("FAIL random_cycle %0d: got %h%h r%b s%b t%b want %h r%b s%b t%b", i, tens_digit, ones_digit,
                     running, sec_tick, timeout, bcd(m_secs), m_state == M_RUN, m_sec_p, m_to_p);
         end
      end
      n_cmp++; if (dut_sec !== m_sec || dut_to !== m_to) begin n_bad++;
         $display("FAIL pulse_totals: got sec=%0d to=%0d want sec=%0d to=%0d", dut_sec, dut_to, m_sec, m_to); end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_pause();
      test_stop();
      test_bonus();
      test_reset_midrun();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
